// File: rtl/frame_store_pkg.sv
// frame_store_pkg: load FSM states, default image geometry and pixel-format conversions
package frame_store_pkg;
  typedef enum logic [1:0] {IDLE, REQ, LOAD, DONE} load_state_t;
  localparam int IMG_PIXELS = 320 * 240;
  function automatic logic [11:0] rgb565_to_444(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: assembles BYTES_PER_PIXEL bytes (first byte = MSB) into one pixel with a strobe
module pixel_packer #(
  parameter int BYTES_PER_PIXEL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  data,
  output logic        pixel_valid,
  output logic [15:0] pixel
);
  logic phase;
  logic last;
  logic [7:0] hi;
  always_comb last = BYTES_PER_PIXEL == 1 || phase;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase <= 1'b0;
      hi <= '0;
      pixel_valid <= 1'b0;
      pixel <= '0;
    end else begin
      pixel_valid <= byte_valid && last;
      if (clr) phase <= 1'b0;
      else if (byte_valid) begin
        phase <= !last;
        hi <= data;
        if (last) pixel <= BYTES_PER_PIXEL == 1 ? {8'h00, data} : {hi, data};
      end
    end
endmodule

// File: rtl/frame_store_controller.sv
// frame_store_controller: loads SD images into RAM slots and scans a selected slot out as RGB444
module frame_store_controller
  import frame_store_pkg::*;
#(
  parameter int IMG_W           = 320,
  parameter int IMG_H           = 240,
  parameter int NUM_IMAGES      = 4,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int RAM_ADDR_W      = 19,
  parameter int SEL_W           = 2
) (
  input  logic                  clk_25MHz,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [SEL_W-1:0]      load_select,
  output logic [31:0]           sd_start_address,
  output logic                  sd_read_req,
  input  logic                  sd_byte_valid,
  input  logic [7:0]            sd_byte,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_waddr,
  output logic [15:0]           ram_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  input  logic                  display_enable,
  input  logic [SEL_W-1:0]      display_select,
  output logic [RAM_ADDR_W-1:0] ram_raddr,
  input  logic [15:0]           ram_rdata,
  output logic                  pix_valid,
  output logic [11:0]           pix_rgb444,
  output logic                  frame_start
);
  localparam int PIXELS = IMG_W * IMG_H;
  localparam logic [RAM_ADDR_W-1:0] LAST = RAM_ADDR_W'(PIXELS - 1);
  localparam logic [RAM_ADDR_W-1:0] SLOT = RAM_ADDR_W'(PIXELS);
  load_state_t state, state_n;
  logic accept;
  logic byte_in;
  logic [RAM_ADDR_W-1:0] wbase, wptr, rptr;
  logic [SEL_W-1:0] shown_slot, scan_slot;
  // out-of-range slots would write past the RAM, so they are refused
  always_comb accept = state == IDLE && load_start && 32'(load_select) < 32'(NUM_IMAGES);
  always_comb byte_in = sd_byte_valid && state == LOAD;
  pixel_packer #(.BYTES_PER_PIXEL(BYTES_PER_PIXEL)) u_packer (
    .clk(clk_25MHz),
    .rst(rst),
    .clr(state == IDLE),
    .byte_valid(byte_in),
    .data(sd_byte),
    .pixel_valid(ram_we),
    .pixel(ram_wdata)
  );
  always_ff @(posedge clk_25MHz or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? REQ : IDLE;
      REQ: state_n = LOAD;
      LOAD: state_n = ram_we && wptr == LAST ? DONE : LOAD;
      default: state_n = IDLE;
    endcase
    sd_read_req = state == REQ;
    load_busy = state == REQ || state == LOAD;
    load_done = state == DONE;
  end
  always_ff @(posedge clk_25MHz or posedge rst)
    if (rst) begin
      sd_start_address <= '0;
      wbase <= '0;
      wptr <= '0;
    end else begin
      if (accept) begin
        sd_start_address <= 32'(load_select) * 32'(PIXELS * BYTES_PER_PIXEL);
        wbase <= RAM_ADDR_W'(load_select) * SLOT;
      end
      wptr <= state != LOAD ? '0 : wptr + RAM_ADDR_W'(ram_we);
    end
  always_comb ram_waddr = wbase + wptr;
  // the first pixel of a frame already uses the new selection, so a whole frame comes from one slot
  always_comb scan_slot = rptr == '0 ? display_select : shown_slot;
  always_comb ram_raddr = RAM_ADDR_W'(scan_slot) * SLOT + rptr;
  always_ff @(posedge clk_25MHz or posedge rst)
    if (rst) begin
      rptr <= '0;
      shown_slot <= '0;
      pix_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (display_enable) begin
        rptr <= rptr == LAST ? '0 : rptr + RAM_ADDR_W'(1);
        if (rptr == '0) shown_slot <= display_select;
      end
      pix_valid <= display_enable;
      frame_start <= display_enable && rptr == '0;
    end
  always_comb pix_rgb444 = !pix_valid ? '0 :
    BYTES_PER_PIXEL == 1 ? rgb332_to_444(ram_rdata[7:0]) : rgb565_to_444(ram_rdata);
endmodule

// File: tb/tb_frame_store_controller.sv
// tb_frame_store_controller: scoreboard bench for an RGB565 instance (8x4) and an RGB332 instance (4x2)
module tb_frame_store_controller;
  localparam int PIX = 32;
  localparam int AW = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic load_start = 1'b0, sd_byte_valid = 1'b0, display_enable = 1'b0;
  logic [1:0] load_select = '0, display_select = '0;
  logic [7:0] sd_byte = '0;
  logic [31:0] sd_start_address;
  logic sd_read_req, ram_we, load_busy, load_done, pix_valid, frame_start;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [15:0] ram_wdata, ram_rdata = '0;
  logic [11:0] pix_rgb444;

  logic b_load_start = 1'b0, b_sd_byte_valid = 1'b0, b_display_enable = 1'b0;
  logic [0:0] b_load_select = '0, b_display_select = '0;
  logic [7:0] b_sd_byte = '0;
  logic [31:0] b_sd_start_address;
  logic b_sd_read_req, b_ram_we, b_load_busy, b_load_done, b_pix_valid, b_frame_start;
  logic [3:0] b_ram_waddr, b_ram_raddr;
  logic [15:0] b_ram_wdata, b_ram_rdata = '0;
  logic [11:0] b_pix_rgb444;

  frame_store_controller #(.IMG_W(8), .IMG_H(4), .NUM_IMAGES(4), .BYTES_PER_PIXEL(2),
    .RAM_ADDR_W(AW), .SEL_W(2)) u_dut (
    .clk_25MHz(clk), .rst(rst), .load_start(load_start), .load_select(load_select),
    .sd_start_address(sd_start_address), .sd_read_req(sd_read_req),
    .sd_byte_valid(sd_byte_valid), .sd_byte(sd_byte), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .load_busy(load_busy),
    .load_done(load_done), .display_enable(display_enable),
    .display_select(display_select), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .pix_valid(pix_valid), .pix_rgb444(pix_rgb444), .frame_start(frame_start));

  frame_store_controller #(.IMG_W(4), .IMG_H(2), .NUM_IMAGES(2), .BYTES_PER_PIXEL(1),
    .RAM_ADDR_W(4), .SEL_W(1)) u_dut_b (
    .clk_25MHz(clk), .rst(rst), .load_start(b_load_start), .load_select(b_load_select),
    .sd_start_address(b_sd_start_address), .sd_read_req(b_sd_read_req),
    .sd_byte_valid(b_sd_byte_valid), .sd_byte(b_sd_byte), .ram_we(b_ram_we),
    .ram_waddr(b_ram_waddr), .ram_wdata(b_ram_wdata), .load_busy(b_load_busy),
    .load_done(b_load_done), .display_enable(b_display_enable),
    .display_select(b_display_select), .ram_raddr(b_ram_raddr), .ram_rdata(b_ram_rdata),
    .pix_valid(b_pix_valid), .pix_rgb444(b_pix_rgb444), .frame_start(b_frame_start));

  logic [15:0] mem_a [0:127];
  logic [15:0] mem_b [0:15];
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_waddr] <= ram_wdata;
    ram_rdata <= mem_a[ram_raddr];
    if (b_ram_we) mem_b[b_ram_waddr] <= b_ram_wdata;
    b_ram_rdata <= mem_b[b_ram_raddr];
  end

  int checks = 0, fails = 0;
  int n_req = 0, n_done = 0, nb_req = 0, nb_done = 0, we_a = 0;
  logic [31:0] exp_wa[$], exp_wb[$], exp_pa[$], exp_pb[$];
  logic [AW-1:0] prev_ra = '0;
  logic [3:0] prev_rb = '0;
  logic [7:0] bb [8] = '{8'hE3, 8'h6D, 8'h00, 8'hFF, 8'h1C, 8'h92, 8'h49, 8'h25};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    fails++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  function automatic logic [15:0] pdata(input int s, input int p);
    return (s == 0 && p == 0) ? 16'hF81F : 16'((s + 1) * 'h2345 + p * 'h0B17);
  endfunction

  function automatic logic [11:0] exp565(input logic [15:0] d);
    return {4'(d >> 12), 4'((d >> 7) & 15), 4'((d >> 1) & 15)};
  endfunction

  function automatic logic [11:0] exp332(input logic [7:0] d);
    int r, g, b;
    r = d >> 5;
    g = (d >> 2) & 7;
    b = d & 3;
    return {4'(r * 2 + (r >> 2)), 4'(g * 2 + (g >> 2)), 4'(b * 5)};
  endfunction

  always @(negedge clk) begin
    if (sd_read_req) n_req++;
    if (load_done) n_done++;
    if (b_sd_read_req) nb_req++;
    if (b_load_done) nb_done++;
    if (ram_we) begin
      we_a++;
      if (exp_wa.size() == 0) unexpected("wr_a", {9'h0, ram_waddr, ram_wdata});
      else check("wr_a", {9'h0, ram_waddr, ram_wdata}, exp_wa.pop_front());
    end
    if (b_ram_we) begin
      if (exp_wb.size() == 0) unexpected("wr_b", {12'h0, b_ram_waddr, b_ram_wdata});
      else check("wr_b", {12'h0, b_ram_waddr, b_ram_wdata}, exp_wb.pop_front());
    end
    if (pix_valid) begin
      if (exp_pa.size() == 0) unexpected("pix_a", {12'h0, prev_ra, frame_start, pix_rgb444});
      else check("pix_a", {12'h0, prev_ra, frame_start, pix_rgb444}, exp_pa.pop_front());
    end
    if (b_pix_valid) begin
      if (exp_pb.size() == 0) unexpected("pix_b", {15'h0, prev_rb, b_frame_start, b_pix_rgb444});
      else check("pix_b", {15'h0, prev_rb, b_frame_start, b_pix_rgb444}, exp_pb.pop_front());
    end
    prev_ra = ram_raddr;
    prev_rb = b_ram_raddr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs;
    check("rst_ctl_a", {26'h0, load_busy, load_done, sd_read_req, ram_we, pix_valid, frame_start}, 0);
    check("rst_sd_addr_a", sd_start_address, 0);
    check("rst_wr_a", {9'h0, ram_waddr, ram_wdata}, 0);
    check("rst_rd_a", {13'h0, ram_raddr, pix_rgb444}, 0);
    check("rst_ctl_b", {26'h0, b_load_busy, b_load_done, b_sd_read_req, b_ram_we, b_pix_valid, b_frame_start}, 0);
  endtask

  task automatic load_a(input int s, input int npix, input bit poke);
    int t;
    load_select = 2'(s);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("req_a", sd_read_req, 1);
    tick;
    check("busy_load_a", load_busy, 1);
    for (int p = 0; p < npix; p++) begin
      exp_wa.push_back({9'h0, 7'(s * PIX + p), pdata(s, p)});
      sd_byte_valid = 1'b1;
      sd_byte = pdata(s, p)[15:8];
      tick;
      sd_byte = pdata(s, p)[7:0];
      if (poke && p == 5) begin
        load_start = 1'b1;
        load_select = 2'd3;
      end
      tick;
      load_start = 1'b0;
    end
    sd_byte_valid = 1'b0;
    if (npix == PIX) begin
      t = 0;
      while (!load_done && t < 8) begin
        tick;
        t++;
      end
      check("done_a", load_done, 1);
      check("busy_done_a", load_busy, 0);
      tick;
    end
  endtask

  task automatic load_b(input int s);
    int t;
    b_load_select = 1'(s);
    b_load_start = 1'b1;
    tick;
    b_load_start = 1'b0;
    check("req_b", b_sd_read_req, 1);
    tick;
    for (int p = 0; p < 8; p++) begin
      exp_wb.push_back({12'h0, 4'(s * 8 + p), 8'h00, bb[p]});
      b_sd_byte_valid = 1'b1;
      b_sd_byte = bb[p];
      tick;
    end
    b_sd_byte_valid = 1'b0;
    t = 0;
    while (!b_load_done && t < 8) begin
      tick;
      t++;
    end
    check("done_b", b_load_done, 1);
    tick;
  endtask

  initial begin
    int r0, d0, w0;
    for (int i = 0; i < 128; i++) mem_a[i] = '0;
    for (int i = 0; i < 16; i++) mem_b[i] = '0;
    tick;
    tick;
    check_reset_outs();
    rst = 1'b0;
    tick;

    r0 = n_req;
    d0 = n_done;
    load_a(1, PIX, 1'b1);
    check("sd_addr_slot1", sd_start_address, 64);
    check("req_count_1", n_req - r0, 1);
    check("done_count_1", n_done - d0, 1);
    check("wq_empty_1", exp_wa.size(), 0);

    w0 = we_a;
    sd_byte_valid = 1'b1;
    sd_byte = 8'hAA;
    repeat (3) tick;
    sd_byte_valid = 1'b0;
    repeat (2) tick;
    check("stray_we", we_a - w0, 0);
    check("stray_idle_busy", load_busy, 0);

    load_a(0, PIX, 1'b0);
    load_a(2, PIX, 1'b0);
    check("sd_addr_slot2", sd_start_address, 128);

    display_select = 2'd0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) display_select = 2'd2;
      if (i == 40) begin
        display_enable = 1'b0;
        repeat (3) tick;
      end
      display_enable = 1'b1;
      exp_pa.push_back({12'h0, 7'((i < 32 ? 0 : 2) * PIX + i % 32), 1'(i % 32 == 0),
                        exp565(pdata(i < 32 ? 0 : 2, i % 32))});
      tick;
    end
    display_enable = 1'b0;
    display_select = 2'd0;
    repeat (2) tick;
    check("pq_empty_a", exp_pa.size(), 0);

    d0 = n_done;
    load_a(3, 10, 1'b0);
    tick;
    sd_byte_valid = 1'b1;
    sd_byte = 8'h12;
    tick;
    rst = 1'b1;
    sd_byte_valid = 1'b0;
    #1;
    check_reset_outs();
    repeat (2) tick;
    rst = 1'b0;
    tick;
    check("abort_no_done", n_done - d0, 0);
    check("abort_wq_empty", exp_wa.size(), 0);
    load_a(3, PIX, 1'b0);
    check("sd_addr_slot3", sd_start_address, 192);
    check("done_count_3", n_done - d0, 1);
    check("wq_empty_3", exp_wa.size(), 0);

    r0 = nb_req;
    d0 = nb_done;
    load_b(1);
    check("sd_addr_b", b_sd_start_address, 8);
    check("req_count_b", nb_req - r0, 1);
    check("done_count_b", nb_done - d0, 1);
    b_display_select = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_display_enable = 1'b1;
      exp_pb.push_back({15'h0, 4'(8 + i % 8), 1'(i % 8 == 0), exp332(bb[i % 8])});
      tick;
    end
    b_display_enable = 1'b0;
    repeat (2) tick;
    check("pq_empty_b", exp_pb.size(), 0);
    check("wq_empty_b", exp_wb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
